spi_slave_if: RTL and testbench
===============================

# spi_slave_if

- Serial front end for the SPI single-port RAM: deserialises MOSI frames into 10-bit command/data words for the RAM (`rx_data`/`rx_valid`).
- Captures the RAM's read response (`tx_data`/`tx_valid`) and serialises it onto MISO.
- It is the initiating end of the RAM's `rx_valid`/`tx_valid` interface and sits between the SPI pins and the RAM in the top-level wrapper.

## Interface
- `DATA_W`, 8: RAM data width; `rx_data` is `DATA_W+2` bits wide (2 command bits plus payload).
- `clk` in 1: single system clock; also the SPI bit clock, one bit per cycle.
- `rst` in 1: reset, asynchronous, active-high.
- `ss_n` in 1: slave select, active-low; frame boundary.
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial read data out, MSB first.
- `rx_data` out DATA_W+2: assembled word; bits [9:8] are the command.
- `rx_valid` out 1: one-cycle pulse, `rx_data` valid.
- `tx_data` in DATA_W: RAM read data.
- `tx_valid` in 1: RAM read data valid.

## Operation
- Command codes in `rx_data[9:8]`:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: if `ss_n`=0, go to CHK_CMD.
- CHK_CMD: sample `mosi` as `rx_data[9]`.
  - `ss_n`=1: go to IDLE.
  - `mosi`=0: go to WRITE.
  - `mosi`=1 and `rd_addr_done`=0: go to READ_ADD.
  - `mosi`=1 and `rd_addr_done`=1: go to READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in 9 further bits (`rx_data[8:0]`) using a bit counter.
- After the 10th bit, pulse `rx_valid` for one cycle with the full word.
- Once `rx_valid` has pulsed, further MOSI bits are ignored until `ss_n`=1.
- `rd_addr_done`: internal flag.
  - Set on the `rx_valid` pulse in READ_ADD.
  - Cleared when the last MISO bit of READ_DATA is driven.
- READ_DATA response path, after `rx_valid`:
  - Wait for `tx_valid`=1 and capture `tx_data`.
  - Drive `miso` = `tx_data[7]`, `[6]`, …, `[0]` on 8 consecutive cycles.
  - Then `miso`=0 until `ss_n`=1.
- `tx_valid` is ignored in all states other than the READ_DATA wait.
- The command bit in CHK_CMD selects the state only. Bit 8 is passed through unchecked; the RAM decodes it.

## Timing
- All registers update on posedge `clk`; `ss_n`/`mosi` are sampled on posedge.
- Reset values:
  - State IDLE.
  - `miso`=0, `rx_valid`=0, `rx_data`=0.
  - Bit counter 0, `rd_addr_done`=0.
- Frame cycle numbering, edge E0 = first edge with `ss_n`=0:
  - E0: enter CHK_CMD.
  - E1: bit 9.
  - E2–E10: bits 8..0.
  - `rx_valid`=1 in the cycle after E10 (registered at E10), then returns to 0.
- Read response:
  - The RAM returns `tx_valid` at the earliest 1 cycle after `rx_valid`. Any later latency is tolerated.
  - The first MISO bit is valid the cycle after the `tx_valid` capture edge.
  - `miso` changes only in READ_DATA.
- `ss_n`=1 at any edge: next state IDLE, bit counter cleared, no `rx_valid` for a partial frame.
  - If this happens before READ_ADD's `rx_valid`: `rd_addr_done` is unchanged.
  - If this happens mid-MISO-shift: shifting stops, `miso`=0, and `rd_addr_done` stays 1, so the next read frame retries READ_DATA.
- `ss_n` low for exactly 1 cycle: IDLE→CHK_CMD→IDLE, no output activity.
- `rx_valid` and `tx_valid` high in the same cycle: `tx_valid` is ignored (not yet waiting).
- `rst` mid-frame: immediate return to reset values, no glitch pulse on `rx_valid`.
- Back-to-back frames: `ss_n` high for a minimum of 1 cycle is sufficient.

## Structure
- Shared package `spi_pkg`:
  - State enum `spi_state_e`.
  - Command constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`.
  - `DATA_W` default.
- One sub-module `spi_miso_shifter`, containing the load, 8-bit shift-out and done flag.
- FSM, bit counter and receive shift register live in `spi_slave_if`.
- Target size: ~150–250 lines.

## Test plan
- Write address: `ss_n`=0, MOSI 00_1010_0101 → `rx_data`=10'h0A5, single `rx_valid` pulse the cycle after E10; `miso` stays 0.
- Read pair:
  - Send 10_0000_0011 → `rx_valid`, `rx_data`=10'h203, `rd_addr_done`=1.
  - New frame 11_xxxx_xxxx → `rx_valid`.
  - Drive `tx_valid` with `tx_data`=8'hC3 → `miso` 1,1,0,0,0,0,1,1 on next 8 cycles, then 0; `rd_addr_done`=0.
- Abort: `ss_n`↑ after 5 bits of a write → no `rx_valid`, state IDLE; the next full frame is received correctly.
- Reset: assert `rst` mid-MISO-shift → `miso`=0, `rx_valid`=0, `rd_addr_done`=0 immediately (asynchronously).
- Stray `tx_valid`: pulse it in IDLE and WRITE → no MISO activity. A delayed `tx_valid` (5 cycles after `rx_valid`) in READ_DATA still produces the correct 8 bits.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end of the single-port RAM.
package spi_pkg;

    localparam int DATA_W_DEFAULT = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_miso_shifter.sv
// Loads one RAM read word and drives it onto MISO MSB first, one bit per cycle.
module spi_miso_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              abort,
    output logic              miso,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] sreg;

    // done marks the edge that puts the final bit on the line
    assign done = active && (cnt == CNT_W'(1)) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso   <= 1'b0;
            active <= 1'b0;
            cnt    <= '0;
        end else if (abort) begin
            miso   <= 1'b0;
            active <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            miso   <= data[DATA_W-1];
            active <= 1'b1;
            cnt    <= CNT_W'(DATA_W - 1);
        end else if (active) begin
            if (cnt != '0) begin
                miso <= sreg[DATA_W-1];
                cnt  <= cnt - CNT_W'(1);
            end else begin
                miso   <= 1'b0;
                active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            sreg <= {data[DATA_W-2:0], 1'b0};
        end else if (active) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: assembles 10-bit command words from MOSI and returns RAM read data on MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int RX_W = DATA_W + 2;
    localparam logic [3:0] LAST_BIT = 4'(RX_W - 2);

    spi_state_e      state;
    logic [3:0]      cnt;
    logic [RX_W-2:0] shreg;
    logic            rd_addr_done;
    logic            frame_done;
    logic            wait_tx;
    logic            shift_en;
    logic            load;
    logic            shift_done;

    always_comb begin
        shift_en = 1'b0;
        if (!ss_n) begin
            if (state == CHK_CMD) begin
                shift_en = 1'b1;
            end else if ((state == WRITE || state == READ_ADD || state == READ_DATA) && !frame_done) begin
                shift_en = 1'b1;
            end
        end
    end

    assign load = (state == READ_DATA) && wait_tx && tx_valid && !ss_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rd_addr_done <= 1'b0;
            frame_done   <= 1'b0;
            wait_tx      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (shift_done) begin
                rd_addr_done <= 1'b0;
            end
            if (ss_n) begin
                state      <= IDLE;
                cnt        <= '0;
                frame_done <= 1'b0;
                wait_tx    <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= CHK_CMD;
                    CHK_CMD: begin
                        if (mosi == CMD_WR_ADDR[1]) begin
                            state <= WRITE;
                        end else if (rd_addr_done) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done) begin
                            if (cnt == LAST_BIT) begin
                                rx_data    <= {shreg, mosi};
                                rx_valid   <= 1'b1;
                                frame_done <= 1'b1;
                                cnt        <= '0;
                                if (state == READ_ADD) begin
                                    rd_addr_done <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                        // Waiting starts the cycle after the pulse, so a coincident tx_valid is ignored
                        if (state == READ_DATA && rx_valid) begin
                            wait_tx <= 1'b1;
                        end
                        if (load) begin
                            wait_tx <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {shreg[RX_W-3:0], mosi};
        end
    end

    spi_miso_shifter #(
        .DATA_W(DATA_W)
    ) u_miso_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (tx_data),
        .abort(ss_n),
        .miso (miso),
        .done (shift_done)
    );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk;
    logic       rst;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_cmp = 0;
    int n_err = 0;
    int rxv_cnt = 0;
    int miso_hi = 0;
    int base_rxv;
    int base_miso;
    logic [7:0] word;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;
        if (miso === 1'b1) miso_hi <= miso_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drops ss_n, then drives n bits of w MSB first; returns at the negedge after the last sampled bit.
    task automatic send_bits(input logic [9:0] w, input int n, input bit stray);
        @(negedge clk);
        ss_n = 1'b0;
        mosi = 1'b0;
        for (int i = 9; i > 9 - n; i--) begin
            @(negedge clk);
            mosi = w[i];
            tx_valid = stray && (i == 5);
            tx_data = 8'hFF;
        end
        @(negedge clk);
        mosi = 1'b0;
        tx_valid = 1'b0;
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] b);
        check(tag, 32'(miso), 32'(b[7]));
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            check(tag, 32'(miso), 32'(b[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_rxv", 32'(rx_valid), 32'd0);
        check("rst_rxd", 32'(rx_data), 32'd0);
        check("rst_rad", 32'(dut.rd_addr_done), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // write address with a stray tx_valid mid-frame
        base_rxv = rxv_cnt;
        base_miso = miso_hi;
        send_bits(10'h0A5, 10, 1'b1);
        check("wr_rxv", 32'(rx_valid), 32'd1);
        check("wr_rxd", 32'(rx_data), 32'h0A5);
        mosi = 1'b1;
        @(negedge clk);
        check("wr_rxv_low", 32'(rx_valid), 32'd0);
        repeat (3) @(negedge clk);
        mosi = 1'b0;
        end_frame();
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        check("wr_pulses", 32'(rxv_cnt - base_rxv), 32'd1);
        check("wr_miso", 32'(miso_hi - base_miso), 32'd0);
        check("wr_rxd_hold", 32'(rx_data), 32'h0A5);

        // ss_n low for a single cycle
        base_rxv = rxv_cnt;
        ss_n = 1'b0;
        @(negedge clk);
        ss_n = 1'b1;
        repeat (2) @(negedge clk);
        check("blip_state", 32'(dut.state), 32'(IDLE));
        check("blip_rxv", 32'(rxv_cnt - base_rxv), 32'd0);

        // read address then read data; tx_valid coincident with rx_valid must be ignored
        send_bits({CMD_RD_ADDR, 8'h03}, 10, 1'b0);
        check("ra_rxd", 32'(rx_data), 32'h203);
        check("ra_rxv", 32'(rx_valid), 32'd1);
        check("ra_done", 32'(dut.rd_addr_done), 32'd1);
        end_frame();
        send_bits({CMD_RD_DATA, 8'h5A}, 10, 1'b0);
        check("rd_rxd", 32'(rx_data), 32'h35A);
        check("rd_rxv", 32'(rx_valid), 32'd1);
        tx_valid = 1'b1;
        tx_data = 8'hAA;
        @(negedge clk);
        tx_data = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        check_byte("rd_bits", 8'hC3);
        check("rd_done_clr", 32'(dut.rd_addr_done), 32'd0);
        @(negedge clk);
        check("rd_tail0", 32'(miso), 32'd0);
        @(negedge clk);
        check("rd_tail1", 32'(miso), 32'd0);
        end_frame();

        // abort a write after 5 bits, then a full frame
        base_rxv = rxv_cnt;
        send_bits({CMD_WR_DATA, 8'h7F}, 5, 1'b0);
        end_frame();
        check("ab_state", 32'(dut.state), 32'(IDLE));
        check("ab_rxv", 32'(rxv_cnt - base_rxv), 32'd0);
        send_bits(10'h13C, 10, 1'b0);
        check("ab_next_rxd", 32'(rx_data), 32'h13C);
        check("ab_next_rxv", 32'(rx_valid), 32'd1);
        end_frame();

        // read data with tx_valid delayed five cycles
        send_bits(10'h2F0, 10, 1'b0);
        end_frame();
        send_bits(10'h300, 10, 1'b0);
        base_miso = miso_hi;
        repeat (5) @(negedge clk);
        check("dl_wait_miso", 32'(miso_hi - base_miso), 32'd0);
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        @(negedge clk);
        tx_valid = 1'b0;
        check_byte("dl_bits", 8'h5A);
        check("dl_done_clr", 32'(dut.rd_addr_done), 32'd0);
        end_frame();

        // abort mid-MISO shift keeps rd_addr_done so the next frame retries
        send_bits(10'h201, 10, 1'b0);
        end_frame();
        send_bits(10'h3AA, 10, 1'b0);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'h96;
        @(negedge clk);
        tx_valid = 1'b0;
        word = 8'h96;
        check("mab_b7", 32'(miso), 32'(word[7]));
        @(negedge clk);
        @(negedge clk);
        check("mab_b5", 32'(miso), 32'(word[5]));
        end_frame();
        check("mab_miso", 32'(miso), 32'd0);
        check("mab_done", 32'(dut.rd_addr_done), 32'd1);
        send_bits(10'h300, 10, 1'b0);
        check("retry_state", 32'(dut.state), 32'(READ_DATA));

        // asynchronous reset in the middle of a MISO shift
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = 8'hF0;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        check("rs_pre_miso", 32'(miso), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rs_miso", 32'(miso), 32'd0);
        check("rs_rxv", 32'(rx_valid), 32'd0);
        check("rs_done", 32'(dut.rd_addr_done), 32'd0);
        check("rs_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        ss_n = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
